// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and counter width.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int CNT_W = 8;

endpackage

// File: rtl/full_adder.sv
// Single-bit combinational full adder cell.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder slice, LSB first, carry held in a flop.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   state_t             r_state;
   state_t             w_next_state;
   logic [WIDTH-1:0]   r_a_sr;
   logic [WIDTH-1:0]   r_b_sr;
   logic [WIDTH-1:0]   r_sum;
   logic               r_carry;
   logic               r_cout;
   logic [CNT_W-1:0]   r_cnt;
   logic               w_fa_sum;
   logic               w_fa_cout;
   logic               w_last;
   logic [WIDTH-1:0]   w_sum_shift;

   full_adder u_fa (
      .a    (r_a_sr[0]),
      .b    (r_b_sr[0]),
      .cin  (r_carry),
      .sum  (w_fa_sum),
      .cout (w_fa_cout)
   );

   assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

   // A one-bit result register has no upper bits to shift down.
   generate
      if (WIDTH == 1) begin : g_sum_w1
         assign w_sum_shift = w_fa_sum;
      end else begin : g_sum_wn
         assign w_sum_shift = {w_fa_sum, r_sum[WIDTH-1:1]};
      end
   endgenerate

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (start) w_next_state = SHIFT;
         SHIFT:   if (w_last) w_next_state = DONE;
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a_sr  <= '0;
         r_b_sr  <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_a_sr  <= a;
                  r_b_sr  <= b;
                  r_carry <= cin;
                  r_cnt   <= '0;
               end
            end
            SHIFT: begin
               r_sum   <= w_sum_shift;
               r_carry <= w_fa_cout;
               r_a_sr  <= r_a_sr >> 1;
               r_b_sr  <= r_b_sr >> 1;
               r_cnt   <= r_cnt + 1'b1;
               if (w_last) r_cout <= w_fa_cout;
            end
            default: ;
         endcase
      end
   end

   assign busy = (r_state != IDLE);
   assign done = (r_state == DONE);
   assign sum  = r_sum;
   assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomized self-checking bench for serial_adder at WIDTH 8, 1 and 13.
module tb_serial_adder;

   logic        clk;
   logic        rst;

   logic        start8, cin8, busy8, done8, cout8;
   logic [7:0]  a8, b8, sum8;
   logic        start1, cin1, busy1, done1, cout1;
   logic [0:0]  a1, b1, sum1;
   logic        start13, cin13, busy13, done13, cout13;
   logic [12:0] a13, b13, sum13;

   int checks = 0;
   int errors = 0;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
   );

   serial_adder #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
   );

   serial_adder #(.WIDTH(13)) dut13 (
      .clk(clk), .rst(rst), .start(start13), .a(a13), .b(b13), .cin(cin13),
      .busy(busy13), .done(done13), .sum(sum13), .cout(cout13)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one WIDTH=8 addition; returns edges from E0 to done, busy cycle count and result.
   task automatic add8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                       output int lat, output int bcyc, output logic [7:0] os, output logic oc);
      a8 = ia; b8 = ib; cin8 = ic; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      lat = 0; bcyc = 0;
      while (done8 !== 1'b1 && lat < 40) begin
         if (busy8 === 1'b1) bcyc++;
         tick();
         lat++;
      end
      os = sum8; oc = cout8;
      if (busy8 === 1'b1) bcyc++;
      tick();
   endtask

   task automatic add13(input logic [12:0] ia, input logic [12:0] ib, input logic ic,
                        output int lat, output logic [12:0] os, output logic oc);
      a13 = ia; b13 = ib; cin13 = ic; start13 = 1'b1;
      tick();
      start13 = 1'b0;
      lat = 0;
      while (done13 !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      os = sum13; oc = cout13;
      tick();
   endtask

   task automatic test_reset_state();
      checks++;
      if ({busy8, done8, cout8, sum8} !== 11'h0) begin
         errors++;
         $display("FAIL reset_state_w8: got busy=%b done=%b cout=%b sum=%h, want all 0", busy8, done8, cout8, sum8);
      end
      checks++;
      if ({busy1, done1, cout1, sum1} !== 4'h0 || {busy13, done13, cout13, sum13} !== 16'h0) begin
         errors++;
         $display("FAIL reset_state_w1_w13: got w1=%b%b%b%b w13=%b%b%b%h, want all 0",
                  busy1, done1, cout1, sum1, busy13, done13, cout13, sum13);
      end
   endtask

   task automatic test_basic();
      int lat, bcyc;
      logic [7:0] s;
      logic c;
      add8(8'h5A, 8'h33, 1'b0, lat, bcyc, s, c);
      checks++;
      if (lat !== 8) begin
         errors++;
         $display("FAIL basic_latency: got %0d edges after E0, want 8", lat);
      end
      checks++;
      if ({c, s} !== 9'h08D) begin
         errors++;
         $display("FAIL basic_result: got cout=%b sum=%h, want cout=0 sum=8d", c, s);
      end
      checks++;
      if (bcyc !== 9) begin
         errors++;
         $display("FAIL basic_busy_cycles: got %0d, want 9", bcyc);
      end
      checks++;
      if (busy8 !== 1'b0 || done8 !== 1'b0) begin
         errors++;
         $display("FAIL basic_done_pulse: got busy=%b done=%b after pulse, want 0 0", busy8, done8);
      end
   endtask

   task automatic test_carry();
      int lat, bcyc;
      logic [7:0] s;
      logic c;
      add8(8'hFF, 8'h01, 1'b0, lat, bcyc, s, c);
      checks++;
      if ({c, s} !== 9'h100) begin
         errors++;
         $display("FAIL carry_ff_01: got cout=%b sum=%h, want cout=1 sum=00", c, s);
      end
      add8(8'hFF, 8'hFF, 1'b1, lat, bcyc, s, c);
      checks++;
      if ({c, s} !== 9'h1FF) begin
         errors++;
         $display("FAIL carry_ff_ff_1: got cout=%b sum=%h, want cout=1 sum=ff", c, s);
      end
   endtask

   task automatic test_reset_mid();
      int lat, bcyc, seen;
      logic [7:0] s;
      logic c;
      a8 = 8'h5A; b8 = 8'h33; cin8 = 1'b0; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      tick();
      tick();
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({busy8, done8, cout8, sum8} !== 11'h0) begin
         errors++;
         $display("FAIL reset_mid_async: got busy=%b done=%b cout=%b sum=%h, want all 0", busy8, done8, cout8, sum8);
      end
      tick();
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (done8 === 1'b1) seen++;
         tick();
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL reset_mid_no_done: got %0d done cycles, want 0", seen);
      end
      add8(8'h12, 8'h34, 1'b1, lat, bcyc, s, c);
      checks++;
      if ({c, s} !== 9'h047 || lat !== 8) begin
         errors++;
         $display("FAIL reset_mid_recover: got cout=%b sum=%h lat=%0d, want cout=0 sum=47 lat=8", c, s, lat);
      end
   endtask

   task automatic test_ignored_start();
      int lat;
      logic [7:0] hs;
      logic hc;
      a8 = 8'h5A; b8 = 8'h33; cin8 = 1'b0; start8 = 1'b1;
      tick();
      lat = 0;
      while (done8 !== 1'b1 && lat < 40) begin
         a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
         tick();
         lat++;
      end
      checks++;
      if (lat !== 8 || {cout8, sum8} !== 9'h08D) begin
         errors++;
         $display("FAIL ignored_start_first: got lat=%0d cout=%b sum=%h, want lat=8 cout=0 sum=8d", lat, cout8, sum8);
      end
      a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0;
      tick();
      checks++;
      if (busy8 !== 1'b0) begin
         errors++;
         $display("FAIL ignored_start_idle: got busy=%b after done, want 0", busy8);
      end
      tick();
      start8 = 1'b0;
      lat = 0;
      while (done8 !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      checks++;
      if (lat !== 8 || {cout8, sum8} !== 9'h100) begin
         errors++;
         $display("FAIL ignored_start_second: got lat=%0d cout=%b sum=%h, want lat=8 cout=1 sum=00", lat, cout8, sum8);
      end
      hs = sum8; hc = cout8;
      for (int i = 0; i < 6; i++) begin
         a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
         tick();
      end
      checks++;
      if (sum8 !== 8'h00 || cout8 !== 1'b1 || busy8 !== 1'b0) begin
         errors++;
         $display("FAIL result_hold: got cout=%b sum=%h busy=%b, want cout=%b sum=%h busy=0", cout8, sum8, busy8, hc, hs);
      end
   endtask

   task automatic test_width1();
      logic [1:0] expv [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
      int lat;
      for (int i = 0; i < 8; i++) begin
         a1 = 1'(i >> 2); b1 = 1'(i >> 1); cin1 = 1'(i); start1 = 1'b1;
         tick();
         start1 = 1'b0;
         lat = 0;
         while (done1 !== 1'b1 && lat < 10) begin
            tick();
            lat++;
         end
         checks++;
         if (lat !== 1 || {cout1, sum1} !== expv[i]) begin
            errors++;
            $display("FAIL width1_case%0d: got lat=%0d {cout,sum}=%b%b, want lat=1 {cout,sum}=%b", i, lat, cout1, sum1, expv[i]);
         end
         tick();
      end
   endtask

   task automatic test_random8();
      int lat, bcyc, bad;
      logic [7:0] ra, rb, s;
      logic rc, c;
      logic [8:0] expv;
      bad = 0;
      for (int n = 0; n < 1000; n++) begin
         ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
         expv = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
         add8(ra, rb, rc, lat, bcyc, s, c);
         checks++;
         if ({c, s} !== expv || lat !== 8 || done8 !== 1'b0) begin
            errors++;
            bad++;
            if (bad < 10)
               $display("FAIL random8_%0d: a=%h b=%h cin=%b got {cout,sum}=%h lat=%0d, want %h lat=8",
                        n, ra, rb, rc, {c, s}, lat, expv);
         end
         repeat ($urandom_range(0, 3)) tick();
      end
   endtask

   task automatic test_random13();
      int lat, bad;
      logic [12:0] ra, rb, s;
      logic rc, c;
      logic [13:0] expv;
      bad = 0;
      for (int n = 0; n < 1000; n++) begin
         ra = 13'($urandom); rb = 13'($urandom); rc = 1'($urandom);
         expv = {1'b0, ra} + {1'b0, rb} + {13'b0, rc};
         add13(ra, rb, rc, lat, s, c);
         checks++;
         if ({c, s} !== expv || lat !== 13 || done13 !== 1'b0) begin
            errors++;
            bad++;
            if (bad < 10)
               $display("FAIL random13_%0d: a=%h b=%h cin=%b got {cout,sum}=%h lat=%0d, want %h lat=13",
                        n, ra, rb, rc, {c, s}, lat, expv);
         end
         repeat ($urandom_range(0, 3)) tick();
      end
   endtask

   initial begin
      clk = 1'b0;
      rst = 1'b1;
      start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
      start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
      start13 = 1'b0; a13 = '0; b13 = '0; cin13 = 1'b0;
      tick();
      tick();
      test_reset_state();
      rst = 1'b0;
      tick();
      test_basic();
      test_carry();
      test_reset_mid();
      test_ignored_start();
      test_width1();
      test_random8();
      test_random13();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial N-bit adder that feeds the existing single-bit full_adder cell one operand bit pair per clock, LSB first, and keeps the ripple carry in a flip-flop between cycles. It accepts two parallel operands on a start strobe, shifts them through the cell, and collects the sum bits in a shift register. It presents a parallel result with a one-cycle done pulse. It is the area-minimal alternative to a ripple chain of full_adder instances and sits between operand registers and any parallel consumer.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 1..255.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request a new addition; sampled only in IDLE
a  input  WIDTH  operand A; captured on the accepting edge
b  input  WIDTH  operand B; captured on the accepting edge
cin  input  1  carry-in; captured on the accepting edge
busy  output  1  high in SHIFT and DONE
done  output  1  one-cycle pulse; sum and cout are valid
sum  output  WIDTH  result register
cout  output  1  final carry-out register

Behaviour:
- Reset is asynchronous, active-high, one clock. On reset: state=IDLE; busy=0, done=0, sum=0, cout=0; operand shift registers, carry flop and bit counter all 0.
- States are IDLE, SHIFT and DONE. busy = (state != IDLE). done = (state == DONE), Moore-decoded from a registered state with no combinational path from inputs.
- IDLE, start=1 at edge E0:
  - load a_sr<=a, b_sr<=b, carry<=cin, cnt<=0;
  - go to SHIFT.
  - sum and cout are not cleared at this point.
- IDLE, start=0: hold all state; sum and cout keep the last result.
- SHIFT, every edge:
  - full_adder inputs are a_sr[0], b_sr[0] and carry;
  - sum <= {fa_sum, sum[WIDTH-1:1]};
  - carry <= fa_cout;
  - a_sr and b_sr shift right by 1, zero-fill;
  - cnt <= cnt+1.
- SHIFT, edge where cnt==WIDTH-1: perform the shift above, also set cout<=fa_cout, and go to DONE.
- DONE: lasts exactly one cycle, then IDLE on the next edge, unconditionally.
- Latency: a start accepted at E0 raises done in the cycle after edge E0+WIDTH. Throughput is one addition per WIDTH+2 cycles, because start is accepted on the edge leaving IDLE.
- start while busy (SHIFT or DONE) is ignored, not queued. Operand and cin changes while busy have no effect.
- sum shows partial values during SHIFT. It is defined only while done=1 and in IDLE after a completed operation. cout changes only on the final shift.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No overflow flag.
- WIDTH=1: SHIFT lasts exactly one edge, and done is high after E0+1.
- Reset mid-operation aborts immediately: done is never asserted for the aborted operation, and the outputs return to reset values.
- Counter width: CNT_W = 8 as a localparam, sufficient for the legal WIDTH range.

Decomposition:
- A shared include file holds the state encoding constants: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2. The undefined encoding 2'd3 recovers to IDLE on the next edge.
- The only sub-module is the existing full_adder, instantiated once. It is the combinational bit slice; no new sub-module is needed.
- Everything else (FSM, shift registers, carry flop, counter) stays flat in serial_adder, giving an estimated 120-160 lines.

Test Plan:
1. Reset: assert rst mid-SHIFT (cycle 3 of an add) -> busy, done, sum and cout go to 0 immediately; no done pulse follows; next start completes normally.
2. WIDTH=8, a=8'h5A, b=8'h33, cin=0 -> done high exactly in the cycle after edge E0+8; sum=8'h8D, cout=0; busy high for 9 cycles.
3. Carry propagation:
   - a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1.
   - a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
4. Ignored start: hold start=1 with changing a/b throughout SHIFT and DONE -> result matches the operands captured at E0. A new add is accepted on the first IDLE edge, and its done arrives WIDTH edges later. Result hold: sum and cout stay stable in IDLE while start=0.
5. WIDTH=1 build: all 8 combinations of a, b, cin -> {cout,sum} equals a+b+cin, and done appears in the cycle after E0+1.
6. WIDTH=8 and WIDTH=13: 1000 random operand/cin sets with random idle gaps -> every done pulse has {cout,sum}=a+b+cin; exactly one done per accepted start.
